lsu_ctrl: RTL and testbench

- Load/store sequencing controller between the core's execute stage and a handshaked data memory.
- Accepts one load or store per transaction and decodes RISC-V funct3.
- Stores: generates word-aligned address, byte enables and lane-replicated write data.
- Loads: stalls the core until memory acknowledges, then selects the byte/half lane and sign/zero-extends the result.

---
 rtl/lsu_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store sequencing controller between the execute stage and a
// handshaked data memory.
//
// Accepts one load or store per transaction (RISC-V funct3 encoding), drives a
// word-aligned memory request with byte enables and lane-replicated store data,
// stalls the core until the memory acknowledges, then returns the selected and
// sign/zero-extended load data with a one-cycle rsp_valid pulse. Illegal funct3
// and misaligned accesses complete immediately as faults without touching memory.
//
// Optional feature: define LSU_ACK_TIMEOUT_EN to enable a bus-timeout fault
// (cause 11) after TIMEOUT_CYCLES BUSY cycles without mem_ack.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid/we/funct3/addr/wdata   core request (sampled in IDLE only)
//   stall                       holds the core while a request is in flight
//   rsp_valid/rsp_rdata         completion pulse and extended load data
//   fault/fault_cause           fault pulse (with rsp_valid) and its cause
//   mem_req/we/addr/be/wdata    memory request, held until mem_ack
//   mem_ack/mem_rdata           memory completion and read word
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] CAUSE_MISAL   = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    // Elaboration-time range check on the timeout limit.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("lsu_ctrl: TIMEOUT_CYCLES out of range 1..65535");
    end

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [29:0] waddr_q, waddr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;

    // ---------------- request decode (IDLE only) ----------------
    logic        is_byte, is_half, is_word;
    logic        illegal, misal;
    logic [3:0]  be_dec;
    logic [31:0] wdata_dec;

    always_comb begin
        is_byte = (req_funct3[1:0] == 2'b00);
        is_half = (req_funct3[1:0] == 2'b01);
        is_word = (req_funct3[1:0] == 2'b10);

        // Stores only have SB/SH/SW; loads add the unsigned LBU/LHU variants.
        if (req_we)
            illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        else
            illegal = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) |
                      (req_funct3 == 3'b111);

        misal = (is_half & req_addr[0]) | (is_word & (req_addr[1:0] != 2'b00));

        be_dec    = 4'b1111;
        wdata_dec = req_wdata;
        if (is_byte) begin
            be_dec    = 4'b0001 << req_addr[1:0];
            wdata_dec = {4{req_wdata[7:0]}};
        end else if (is_half) begin
            be_dec    = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_dec = {2{req_wdata[15:0]}};
        end
    end

    // ---------------- load lane select and extension ----------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
        ld_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'b0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'b0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // ---------------- optional ack timeout ----------------
    logic timeout_hit;
`ifdef LSU_ACK_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    // cnt_q counts completed ack-less BUSY cycles, so the limit is hit on the
    // TIMEOUT_CYCLES-th BUSY cycle.
    assign timeout_hit = (state_q == S_BUSY) && !mem_ack && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != S_BUSY)
            cnt_d = '0;
        else if (!mem_ack)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // ---------------- next state ----------------
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        waddr_d  = waddr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        cause_d  = cause_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    off_d    = req_addr[1:0];
                    waddr_d  = req_addr[31:2];
                    be_d     = be_dec;
                    wdata_d  = wdata_dec;
                    rdata_d  = '0;
                    fault_d  = illegal | misal;
                    cause_d  = illegal ? CAUSE_ILLEGAL :
                               misal   ? CAUSE_MISAL   : 2'b00;
                    state_d  = (illegal | misal) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                // Ack is checked first so a same-cycle ack beats the timeout.
                if (mem_ack) begin
                    rdata_d = we_q ? 32'b0 : ld_ext;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    fault_d = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            off_q    <= '0;
            waddr_q  <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
            cause_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            waddr_q  <= waddr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
            cause_q  <= cause_d;
        end
    end

    // ---------------- outputs ----------------
    logic busy, resp;
    assign busy = (state_q == S_BUSY);
    assign resp = (state_q == S_RESP);

    assign stall       = ((state_q == S_IDLE) & req_valid) | busy;
    assign rsp_valid   = resp;
    assign rsp_rdata   = resp ? rdata_q : 32'b0;
    assign fault       = resp & fault_q;
    assign fault_cause = resp ? cause_q : 2'b00;

    // Memory-side outputs are only meaningful during BUSY; keep them quiet
    // otherwise so a stale request is never visible on the bus.
    assign mem_req   = busy;
    assign mem_we    = busy & we_q;
    assign mem_addr  = busy ? {waddr_q, 2'b00} : 32'b0;
    assign mem_be    = busy ? be_q : 4'b0;
    assign mem_wdata = busy ? wdata_q : 32'b0;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

`ifdef LSU_ACK_TIMEOUT_EN
    localparam int unsigned TB_TO = 8;
`else
    localparam int unsigned TB_TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, rsp_valid, fault;
    logic [31:0] rsp_rdata;
    logic [1:0]  fault_cause;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    lsu_ctrl #(.TIMEOUT_CYCLES(TB_TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .fault(fault), .fault_cause(fault_cause),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;   // word returned by memory on ack
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata; // checked for stores only
        logic [31:0] e_rdata;
        logic [1:0]  e_cause; // nonzero -> immediate fault, no memory access
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input logic [31:0] ea, input logic [3:0] eb,
                                input logic [31:0] ew, input logic [31:0] er,
                                input logic [1:0] ec);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.e_addr = ea; v.e_be = eb; v.e_wdata = ew; v.e_rdata = er; v.e_cause = ec;
        return v;
    endfunction

    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    endtask

    // Applies one vector starting at a negedge with the DUT idle; ends at a negedge, idle.
    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        drive_req(v.we, v.f3, v.addr, v.wdata);
        #1 chk({t, ".stall_c0"}, stall, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;  // must not disturb the latched request
        if (v.e_cause != 2'b00) begin
            chk({t, ".rsp_valid"}, rsp_valid, 1);
            chk({t, ".fault"}, fault, 1);
            chk({t, ".cause"}, fault_cause, v.e_cause);
            chk({t, ".no_memreq"}, mem_req, 0);
            chk({t, ".rdata0"}, rsp_rdata, 0);
        end else begin
            chk({t, ".mem_req"}, mem_req, 1);
            chk({t, ".stall_c1"}, stall, 1);
            chk({t, ".mem_addr"}, mem_addr, v.e_addr);
            chk({t, ".mem_be"}, mem_be, v.e_be);
            chk({t, ".mem_we"}, mem_we, v.we);
            if (v.we) chk({t, ".mem_wdata"}, mem_wdata, v.e_wdata);
            mem_ack = 1'b1; mem_rdata = v.rdata;
            @(posedge clk);
            @(negedge clk);
            mem_ack = 1'b0;
            chk({t, ".rsp_valid"}, rsp_valid, 1);
            chk({t, ".rsp_rdata"}, rsp_rdata, v.e_rdata);
            chk({t, ".fault"}, {fault, fault_cause}, 0);
            chk({t, ".stall_c2"}, stall, 0);
            chk({t, ".memreq_off"}, mem_req, 0);
        end
        @(posedge clk);
        @(negedge clk);
        chk({t, ".rsp_drop"}, rsp_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

        //             we  f3      addr           wdata          rdata          e_addr         be       e_wdata        e_rdata        cause
        vecs[0]  = mk(0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'h0,         32'hDEAD_BEEF, 2'b00);
        vecs[1]  = mk(0, 3'b000, 32'h0000_0103, 32'h0,         32'h8011_2233, 32'h0000_0100, 4'b1000, 32'h0,         32'hFFFF_FF80, 2'b00);
        vecs[2]  = mk(0, 3'b100, 32'h0000_0103, 32'h0,         32'h8011_2233, 32'h0000_0100, 4'b1000, 32'h0,         32'h0000_0080, 2'b00);
        vecs[3]  = mk(0, 3'b001, 32'h0000_0102, 32'h0,         32'h8011_2233, 32'h0000_0100, 4'b1100, 32'h0,         32'hFFFF_8011, 2'b00);
        vecs[4]  = mk(0, 3'b101, 32'h0000_0100, 32'h0,         32'h8011_2233, 32'h0000_0100, 4'b0011, 32'h0,         32'h0000_2233, 2'b00);
        vecs[5]  = mk(1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'h1111_1111, 32'h0000_0200, 4'b0010, 32'hA5A5_A5A5, 32'h0,         2'b00);
        vecs[6]  = mk(1, 3'b001, 32'h0000_0202, 32'h0000_1234, 32'h1111_1111, 32'h0000_0200, 4'b1100, 32'h1234_1234, 32'h0,         2'b00);
        vecs[7]  = mk(1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,         32'h0000_0204, 4'b1111, 32'hCAFE_F00D, 32'h0,         2'b00);
        vecs[8]  = mk(0, 3'b010, 32'h0000_0102, 32'h0,         32'h0,         32'h0,         4'b0000, 32'h0,         32'h0,         2'b01);
        vecs[9]  = mk(0, 3'b011, 32'h0000_0102, 32'h0,         32'h0,         32'h0,         4'b0000, 32'h0,         32'h0,         2'b10);
        vecs[10] = mk(1, 3'b100, 32'h0000_0000, 32'h0,         32'h0,         32'h0,         4'b0000, 32'h0,         32'h0,         2'b10);
        vecs[11] = mk(0, 3'b001, 32'h0000_0101, 32'h0,         32'h0,         32'h0,         4'b0000, 32'h0,         32'h0,         2'b01);
        vecs[12] = mk(0, 3'b000, 32'h0000_0101, 32'h0,         32'h1234_5678, 32'h0000_0100, 4'b0010, 32'h0,         32'h0000_0056, 2'b00);
        vecs[13] = mk(0, 3'b101, 32'h0000_0102, 32'h0,         32'h8234_5678, 32'h0000_0100, 4'b1100, 32'h0,         32'h0000_8234, 2'b00);
        vecs[14] = mk(1, 3'b001, 32'h0000_0203, 32'h0,         32'h0,         32'h0,         4'b0000, 32'h0,         32'h0,         2'b01);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.stall", stall, 0);
        chk("rst.rsp", {rsp_valid, fault, fault_cause}, 0);
        chk("rst.rdata", rsp_rdata, 0);
        chk("rst.mem", {mem_req, mem_we, mem_be}, 0);
        chk("rst.addr", mem_addr, 0);
        rst_n = 1'b1;

        // ack while idle must be ignored
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack.rsp", rsp_valid, 0);
        chk("idle_ack.req", mem_req, 0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Delayed ack: 6 BUSY cycles, address and request held throughout
        drive_req(1'b0, 3'b010, 32'h0000_0300, 32'h0);
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid = 1'b0; req_addr = 32'h0000_0ABC;
            chk($sformatf("dly%0d.mem_req", i), mem_req, 1);
            chk($sformatf("dly%0d.addr", i), mem_addr, 32'h0000_0300);
            chk($sformatf("dly%0d.rsp", i), rsp_valid, 0);
            if (i == 5) begin mem_ack = 1'b1; mem_rdata = 32'h55AA_0FF0; end
            @(posedge clk);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        chk("dly.rsp_valid", rsp_valid, 1);
        chk("dly.rdata", rsp_rdata, 32'h55AA_0FF0);
        @(posedge clk);
        @(negedge clk);

        // Request held through RESP is ignored there, then accepted in IDLE
        drive_req(1'b0, 3'b010, 32'h0000_0106, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b.fault", {fault, fault_cause}, 3'b101);
        chk("b2b.stall_resp", stall, 0);
        req_addr = 32'h0000_0104;
        @(posedge clk);
        @(negedge clk);
        chk("b2b.idle_stall", stall, 1);
        chk("b2b.idle_noreq", mem_req, 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b.busy_addr", mem_addr, 32'h0000_0104);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b.rdata", rsp_rdata, 32'h0BAD_F00D);
        @(posedge clk);
        @(negedge clk);

        // Reset while BUSY drops the request immediately
        drive_req(1'b0, 3'b010, 32'h0000_0400, 32'h0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstb.busy", mem_req, 1);
        #2 rst_n = 1'b0;
        #1 chk("rstb.memreq", mem_req, 0);
        chk("rstb.stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstb.idle", {mem_req, rsp_valid}, 0);
        run_vec(vecs[0], 100);

`ifdef LSU_ACK_TIMEOUT_EN
        // No ack: request held for TB_TO BUSY cycles, then timeout fault
        drive_req(1'b0, 3'b010, 32'h0000_0500, 32'h0);
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            chk($sformatf("to%0d.mem_req", i), mem_req, 1);
            @(posedge clk);
        end
        @(negedge clk);
        chk("to.memreq_drop", mem_req, 0);
        chk("to.rsp", {rsp_valid, fault, fault_cause}, 4'b1111);
        chk("to.rdata", rsp_rdata, 0);
        @(posedge clk);
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
